sdram_slot_arbiter: RTL and testbench
=====================================

Name: sdram_slot_arbiter

Overview:
- Time-slotted arbiter that shares the single CPU/loader port of the sdram controller between three requesters:
  - ioctl download writer (ROM/DCK images);
  - Z80 memory bus;
  - TZX tape-buffer reader.
- One access is granted per clkref slot (ne7M0, every 8 clk_sys).
- The winner's address, data and command are presented to the sdram controller.
- Read data is returned with a one-cycle ack pulse.
- Replaces the combinational download/CPU mux in the top level. The video port of the sdram controller is not involved.

Parameters:
- ADDR_W, 23, sdram byte address width
- LAT, 5, clk_sys cycles from slot start (clkref) to valid sd_dout; legal range 1..6
- STARVE_MAX, 4, consecutive lost slots after which the tape port outranks the CPU port

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clkref  in  1  slot strobe, one-cycle pulse every 8 clk_sys
- dl_req  in  1  download write request (level)
- dl_addr  in  ADDR_W  download address
- dl_din  in  8  download write data
- dl_ack  out  1  download write done pulse
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data, held until next CPU read completes
- cpu_ack  out  1  CPU access done pulse
- tape_req  in  1  tape read request (level)
- tape_addr  in  ADDR_W  tape read address
- tape_dout  out  8  tape read data, held
- tape_ack  out  1  tape read done pulse
- sd_addr  out  ADDR_W  address to sdram controller
- sd_din  out  8  write data to sdram controller
- sd_oe  out  1  read command
- sd_we  out  1  write command
- sd_dout  in  8  read data from sdram controller
- grant  out  2  current owner: 0 none, 1 dl, 2 cpu, 3 tape

Behaviour:
- Reset values (asynchronous): all outputs 0, FSM in IDLE, starvation counter 0.
- FSM states: IDLE, SLOT, DONE.
- IDLE, on clkref:
  - Sample the req inputs and pick a winner.
  - If any request is pending, register the winner's addr, data and command onto sd_*, set grant, enter SLOT with latency counter = 1.
  - If no request is pending, stay in IDLE with sd_oe=sd_we=0.
- Requests raised between clkref pulses wait for the next clkref; they are never granted mid-slot.
- Priority:
  - Normal order: dl > cpu > tape.
  - If the starvation counter >= STARVE_MAX and tape_req=1, order becomes dl > tape > cpu.
  - dl always wins.
- Starvation counter:
  - +1 (saturating at STARVE_MAX) on each clkref where tape_req=1 and tape loses.
  - Cleared when tape is granted or when tape_req=0 at clkref.
- Command encoding per winner:
  - dl: sd_we=1, sd_oe=0.
  - tape: sd_oe=1, sd_we=0.
  - cpu: sd_we=cpu_we, sd_oe=~cpu_we.
- SLOT timing:
  - sd_* are held stable from the cycle after the grant clkref through the cycle of the next clkref.
  - The latency counter increments each cycle.
  - When the counter reaches LAT:
    - for reads, capture sd_dout into cpu_dout or tape_dout;
    - pulse the owner's ack for exactly 1 cycle (writes ack at the same point);
    - go to DONE.
- DONE:
  - Wait for the next clkref, then perform IDLE arbitration in that same cycle.
  - Back-to-back slots are therefore possible with no idle slot.
  - grant drops to 0 and sd_oe/sd_we deassert at that clkref if no request is pending.
- Request lifecycle:
  - A request is single-shot per grant.
  - If req is still high at a later clkref, it is treated as a new access; requesters deassert req on the cycle after ack.
  - A req dropped after grant does not abort the access; ack still pulses.
- clkref arriving in SLOT before LAT is reached is a configuration error, impossible with legal LAT. A simulation assertion flags it.
- Reset asserted mid-slot: outputs clear immediately and no ack is issued. Requesters re-issue after reset.
- dl_req high blocks cpu and tape completely; this is intended because the core is held in reset during download.

Test Plan:
- Single CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x10005. Required: sd_oe=1, sd_addr=0x10005 from clkref+1; with sd_dout=0xA5, cpu_ack pulses at clkref+LAT and cpu_dout=0xA5 thereafter.
- Download priority: dl_req, cpu_req and tape_req all high at one clkref. Required: grant=1, sd_we=1, sd_din=dl_din; cpu is served at the next clkref once dl_req drops.
- Tape starvation: cpu_req and tape_req held high continuously, STARVE_MAX=4. Required: grants cpu, cpu, cpu, cpu, tape, cpu..., i.e. tape in the 5th slot; counter then restarts.
- Mid-slot request: cpu_req rises 3 cycles after a clkref with the arbiter idle. Required: no grant until the next clkref; ack at that clkref+LAT.
- Reset mid-slot: assert reset at clkref+2 during a tape read. Required: all outputs 0 the same cycle, no tape_ack; after release, first grant occurs at the first subsequent clkref.
- Write/read-back: CPU writes 0x3C to 0x04000, then reads 0x04000 against an sdram model. Required: cpu_dout=0x3C, two cpu_ack pulses in consecutive slots.

Source files
------------

// File: rtl/sdram_slot_arbiter.sv
// Time-slotted arbiter sharing the sdram CPU/loader port between the ioctl
// download writer, the Z80 bus and the TZX tape reader, one access per clkref slot.
module sdram_slot_arbiter #(
  parameter int ADDR_W     = 23,
  parameter int LAT        = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              clkref,

  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_din,
  output logic              dl_ack,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,

  input  logic              tape_req,
  input  logic [ADDR_W-1:0] tape_addr,
  output logic [7:0]        tape_dout,
  output logic              tape_ack,

  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  output logic              sd_oe,
  output logic              sd_we,
  input  logic [7:0]        sd_dout,

  output logic [1:0]        grant
);

  // Handshake: each *_req is a level sampled only on clkref while the arbiter
  // is not mid-slot. A sample that wins starts exactly one access; the matching
  // *_ack is a single-cycle pulse LAT cycles after that clkref. Dropping req
  // after the grant does not cancel the access. A req still high at a later
  // clkref is a fresh access.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SLOT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_DL   = 2'd1;
  localparam logic [1:0] G_CPU  = 2'd2;
  localparam logic [1:0] G_TAPE = 2'd3;

  localparam int              SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);
  localparam logic [2:0]      LAT_C      = 3'(LAT);

  logic [1:0]      state;
  logic [2:0]      lat_cnt;
  logic [SC_W-1:0] starve_cnt;
  logic            tape_boost;
  logic [1:0]      win;

  // Tape overtakes the CPU only once it has been passed over STARVE_MAX times.
  always_comb begin
    tape_boost = tape_req && (starve_cnt >= STARVE_LIM);
    win        = G_NONE;
    if (dl_req)
      win = G_DL;
    else if (tape_boost)
      win = G_TAPE;
    else if (cpu_req)
      win = G_CPU;
    else if (tape_req)
      win = G_TAPE;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_cnt    <= 3'd0;
      starve_cnt <= '0;
      grant      <= G_NONE;
      sd_addr    <= '0;
      sd_din     <= 8'h00;
      sd_oe      <= 1'b0;
      sd_we      <= 1'b0;
      dl_ack     <= 1'b0;
      cpu_ack    <= 1'b0;
      tape_ack   <= 1'b0;
      cpu_dout   <= 8'h00;
      tape_dout  <= 8'h00;
    end else begin
      dl_ack   <= 1'b0;
      cpu_ack  <= 1'b0;
      tape_ack <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (clkref) begin
            if (!tape_req || win == G_TAPE)
              starve_cnt <= '0;
            else if (starve_cnt < STARVE_LIM)
              starve_cnt <= starve_cnt + SC_ONE;

            grant <= win;
            case (win)
              G_DL: begin
                sd_addr <= dl_addr;
                sd_din  <= dl_din;
                sd_we   <= 1'b1;
                sd_oe   <= 1'b0;
              end
              G_CPU: begin
                sd_addr <= cpu_addr;
                sd_din  <= cpu_din;
                sd_we   <= cpu_we;
                sd_oe   <= ~cpu_we;
              end
              G_TAPE: begin
                sd_addr <= tape_addr;
                sd_din  <= 8'h00;
                sd_we   <= 1'b0;
                sd_oe   <= 1'b1;
              end
              default: begin
                sd_we <= 1'b0;
                sd_oe <= 1'b0;
              end
            endcase

            if (win != G_NONE) begin
              state   <= S_SLOT;
              lat_cnt <= 3'd1;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_SLOT: begin
          if (lat_cnt == LAT_C) begin
            case (grant)
              G_DL:  dl_ack <= 1'b1;
              G_CPU: begin
                cpu_ack <= 1'b1;
                if (sd_oe)
                  cpu_dout <= sd_dout;
              end
              G_TAPE: begin
                tape_ack  <= 1'b1;
                tape_dout <= sd_dout;
              end
              default: ;
            endcase
            state <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A clkref before the data has come back means LAT is too long for the slot.
  clkref_in_slot: assert property (@(posedge clk_sys) disable iff (reset)
    !(state == S_SLOT && clkref && lat_cnt < LAT_C))
    else $error("clkref arrived before read latency elapsed");
`endif

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: table of single-slot vectors plus hand-written
// sequences for starvation, priority hand-over, mid-slot request, reset and read-back.
module tb_sdram_slot_arbiter;

  localparam int ADDR_W     = 23;
  localparam int LAT        = 5;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic [2:0] phase = 3'd0;
  logic clkref;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) phase <= phase + 3'd1;
  assign clkref = (phase == 3'd7);

  logic              dl_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, tape_req = 1'b0;
  logic [ADDR_W-1:0] dl_addr = '0, cpu_addr = '0, tape_addr = '0;
  logic [7:0]        dl_din = 8'h00, cpu_din = 8'h00;
  logic              dl_ack, cpu_ack, tape_ack, sd_oe, sd_we;
  logic [7:0]        cpu_dout, tape_dout, sd_din, sd_dout;
  logic [ADDR_W-1:0] sd_addr;
  logic [1:0]        grant;

  sdram_slot_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_sys(clk_sys), .reset(reset), .clkref(clkref),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .tape_req(tape_req), .tape_addr(tape_addr), .tape_dout(tape_dout), .tape_ack(tape_ack),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_oe(sd_oe), .sd_we(sd_we), .sd_dout(sd_dout),
    .grant(grant)
  );

  // ---------------- sdram model (low 16 address bits) ----------------
  logic [7:0]  mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [7:0]  pre_data = 8'h00;

  always @(posedge clk_sys) begin
    if (pre_we)
      mem[pre_addr] <= pre_data;
    else if (sd_we)
      mem[sd_addr[15:0]] <= sd_din;
  end
  assign sd_dout = sd_oe ? mem[sd_addr[15:0]] : 8'h00;

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];   // {owner, data} per expected ack

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ack_owner(input logic a, input logic b, input logic c);
    case ({a, b, c})
      3'b100:  return 2'd1;
      3'b010:  return 2'd2;
      3'b001:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Scoreboard: every ack must match the next expected {owner, data}.
  always @(negedge clk_sys) begin
    if (!reset && (dl_ack || cpu_ack || tape_ack)) begin
      logic [1:0] own;
      logic [7:0] dat;
      own = ack_owner(dl_ack, cpu_ack, tape_ack);
      dat = cpu_ack ? cpu_dout : (tape_ack ? tape_dout : 8'h00);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=%0h required=none (t=%0t)", {own, dat}, $time);
      end else begin
        chk("sb_ack", {22'h0, own, dat}, {22'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Returns at the negedge where clkref is high; the next posedge is the slot edge.
  task automatic sync_clkref();
    int n = 0;
    @(negedge clk_sys);
    while (!clkref && n < 16) begin
      @(negedge clk_sys);
      n++;
    end
    if (!clkref) begin
      checks++;
      failures++;
      $display("FAIL clkref_wait actual=0 required=1");
    end
  endtask

  task automatic drop_reqs();
    dl_req = 1'b0; cpu_req = 1'b0; tape_req = 1'b0;
  endtask

  task automatic idle_slot(input string tag);
    sync_clkref();
    step(1);
    chk({tag, "_idle_grant"}, grant, 0);
    chk({tag, "_idle_cmd"}, {sd_oe, sd_we}, 0);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    step(1);
    pre_we = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              dl, cpu, we, tape;
    logic [ADDR_W-1:0] dl_a, cpu_a, tape_a;
    logic [7:0]        dl_d, cpu_d;
    logic [1:0]        e_grant;
    logic              e_oe, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_din, e_cpu_dout, e_tape_dout;
  } vec_t;

  vec_t vecs[6];
  logic [1:0] starve_exp[10];

  initial begin
    vecs[0] = '{0,1,0,0, 23'h00100,23'h10005,23'h07ABC, 8'h11,8'h00, 2'd2,1,0, 23'h10005, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{0,1,1,0, 23'h00100,23'h04000,23'h07ABC, 8'h11,8'h3C, 2'd2,0,1, 23'h04000, 8'h3C, 8'hA5, 8'h00};
    vecs[2] = '{1,1,0,1, 23'h00100,23'h10005,23'h07ABC, 8'h11,8'h00, 2'd1,0,1, 23'h00100, 8'h11, 8'hA5, 8'h00};
    vecs[3] = '{0,0,0,1, 23'h00100,23'h10005,23'h07ABC, 8'h11,8'h00, 2'd3,1,0, 23'h07ABC, 8'h00, 8'hA5, 8'h5A};
    vecs[4] = '{0,1,0,1, 23'h00100,23'h04000,23'h07ABC, 8'h11,8'h77, 2'd2,1,0, 23'h04000, 8'h77, 8'h3C, 8'h5A};
    vecs[5] = '{1,0,0,0, 23'h00200,23'h10005,23'h07ABC, 8'hE7,8'h00, 2'd1,0,1, 23'h00200, 8'hE7, 8'h3C, 8'h5A};
    starve_exp = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};

    // ---- reset state ----
    preload(16'h0005, 8'hA5);
    preload(16'h7ABC, 8'h5A);
    step(2);
    chk("rst_grant", grant, 0);
    chk("rst_cmd", {sd_oe, sd_we}, 0);
    chk("rst_acks", {dl_ack, cpu_ack, tape_ack}, 0);
    chk("rst_data", {sd_addr, sd_din, cpu_dout, tape_dout}, 0);
    reset = 1'b0;

    // ---- table-driven single slots ----
    for (int i = 0; i < 6; i++) begin
      logic [2:0] exp_acks;
      sync_clkref();
      dl_req = vecs[i].dl; cpu_req = vecs[i].cpu; cpu_we = vecs[i].we; tape_req = vecs[i].tape;
      dl_addr = vecs[i].dl_a; cpu_addr = vecs[i].cpu_a; tape_addr = vecs[i].tape_a;
      dl_din = vecs[i].dl_d; cpu_din = vecs[i].cpu_d;
      exp_q.push_back({vecs[i].e_grant, vecs[i].e_grant == 2'd2 ? vecs[i].e_cpu_dout :
                       vecs[i].e_grant == 2'd3 ? vecs[i].e_tape_dout : 8'h00});
      exp_acks = (vecs[i].e_grant == 2'd1) ? 3'b100 : (vecs[i].e_grant == 2'd2) ? 3'b010 : 3'b001;
      step(1);
      drop_reqs();
      chk($sformatf("v%0d_grant", i), grant, vecs[i].e_grant);
      chk($sformatf("v%0d_cmd", i), {sd_oe, sd_we}, {vecs[i].e_oe, vecs[i].e_we});
      chk($sformatf("v%0d_addr", i), sd_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_din", i), sd_din, vecs[i].e_din);
      step(LAT - 1);
      chk($sformatf("v%0d_early_ack", i), {dl_ack, cpu_ack, tape_ack}, 0);
      step(1);
      chk($sformatf("v%0d_ack", i), {dl_ack, cpu_ack, tape_ack}, exp_acks);
      chk($sformatf("v%0d_dout", i), {cpu_dout, tape_dout}, {vecs[i].e_cpu_dout, vecs[i].e_tape_dout});
      step(1);
      chk($sformatf("v%0d_ack_pulse", i), {dl_ack, cpu_ack, tape_ack}, 0);
      chk($sformatf("v%0d_addr_hold", i), sd_addr, vecs[i].e_addr);
      idle_slot($sformatf("v%0d", i));
    end

    // ---- download priority hand-over ----
    sync_clkref();
    dl_req = 1'b1; dl_addr = 23'h00300; dl_din = 8'h5C;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h04000;
    tape_req = 1'b1; tape_addr = 23'h07ABC;
    exp_q.push_back({2'd1, 8'h00});
    step(1);
    dl_req = 1'b0;
    chk("dlpri_grant", grant, 1);
    chk("dlpri_we_din", {sd_we, sd_oe, sd_din}, {1'b1, 1'b0, 8'h5C});
    sync_clkref();
    exp_q.push_back({2'd2, 8'h3C});
    step(1);
    drop_reqs();
    chk("dlpri_cpu_next", grant, 2);
    chk("dlpri_cpu_oe", sd_oe, 1);
    idle_slot("dlpri");

    // ---- tape starvation: cpu and tape held continuously ----
    cpu_addr = 23'h10005; cpu_we = 1'b0; tape_addr = 23'h07ABC;
    for (int s = 0; s < 10; s++) begin
      sync_clkref();
      cpu_req = 1'b1; tape_req = 1'b1;
      exp_q.push_back({starve_exp[s], starve_exp[s] == 2'd2 ? 8'hA5 : 8'h5A});
      step(1);
      chk($sformatf("starve_slot%0d", s), grant, starve_exp[s]);
    end
    drop_reqs();
    idle_slot("starve");

    // ---- request raised mid-slot waits for next clkref ----
    sync_clkref();
    step(1);
    chk("mid_idle", grant, 0);
    step(3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h10005;
    exp_q.push_back({2'd2, 8'hA5});
    sync_clkref();
    chk("mid_no_grant", {grant, sd_oe, sd_we}, 0);
    step(1);
    cpu_req = 1'b0;
    chk("mid_grant", grant, 2);
    step(LAT - 1);
    chk("mid_early_ack", cpu_ack, 0);
    step(1);
    chk("mid_ack", cpu_ack, 1);
    chk("mid_dout", cpu_dout, 8'hA5);
    idle_slot("mid");

    // ---- write then read back in consecutive slots ----
    preload(16'h4000, 8'h00);
    sync_clkref();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h04000; cpu_din = 8'h3C;
    exp_q.push_back({2'd2, 8'hA5});
    step(1);
    chk("wr_cmd", {grant, sd_we, sd_oe, sd_din}, {2'd2, 1'b1, 1'b0, 8'h3C});
    step(LAT);
    chk("wr_ack", cpu_ack, 1);
    step(1);
    cpu_we = 1'b0;
    sync_clkref();
    exp_q.push_back({2'd2, 8'h3C});
    step(1);
    cpu_req = 1'b0;
    chk("rd_cmd", {grant, sd_we, sd_oe}, {2'd2, 1'b0, 1'b1});
    step(LAT);
    chk("rd_ack", cpu_ack, 1);
    chk("rd_dout", cpu_dout, 8'h3C);
    idle_slot("wrrd");

    // ---- reset in the middle of a tape read ----
    sync_clkref();
    tape_req = 1'b1; tape_addr = 23'h07ABC;
    step(1);
    tape_req = 1'b0;
    chk("rstmid_grant", grant, 3);
    step(2);
    reset = 1'b1;
    #1;
    chk("rstmid_grant_clr", grant, 0);
    chk("rstmid_cmd_clr", {sd_oe, sd_we, sd_addr}, 0);
    chk("rstmid_dout_clr", {tape_dout, cpu_dout}, 0);
    step(2);
    reset = 1'b0;
    step(2);
    chk("rstmid_no_ack", tape_ack, 0);
    tape_req = 1'b1;
    sync_clkref();
    chk("rstmid_wait", grant, 0);
    exp_q.push_back({2'd3, 8'h5A});
    step(1);
    tape_req = 1'b0;
    chk("rstmid_regrant", grant, 3);
    step(LAT);
    chk("rstmid_ack", tape_ack, 1);
    chk("rstmid_tape_dout", tape_dout, 8'h5A);
    idle_slot("rstmid");

    // ---- report ----
    step(4);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
